// File: rtl/exec_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// exec_wb_arbiter_pkg
// Shared definitions for the execution writeback arbiter: the per-slot state
// encoding, the default latency-counter width and the round-robin pointer
// advance helper. Also supplies fallback values for the global width macros
// when no project-wide header has defined them.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_ID_SIZE
`define ROB_ID_SIZE 6
`endif
`ifndef DEST_ADDR_SIZE
`define DEST_ADDR_SIZE 5
`endif

package exec_wb_arbiter_pkg;

    // Lifecycle of one functional-unit slot.
    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_e;

    localparam int LAT_WIDTH_DEFAULT = 4;

    // Pointer position just after a granted slot, wrapping at n-1 -> 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/exec_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin selection over a request vector. The search starts at 'ptr' and
// walks upward with wrap-around; the first requester found wins.
// Ports:
//   req         in   N      request vector (one bit per slot)
//   ptr         in   IDX_W  slot with highest priority this cycle (< N)
//   grant       out  N      one-hot grant
//   grant_idx   out  IDX_W  index of the granted slot (0 when none)
//   grant_valid out  1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin : search
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/exec_wb_arbiter.sv
// ---------------------------------------------------------------------------
// exec_wb_arbiter
// Tracks NUM_FU functional-unit slots from issue to writeback. Each slot
// counts down its issue latency, captures its unit's result, and then waits
// for a round-robin grant onto the single writeback port.
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   issue_valid/fu/latency/rob/dest/ctrl   issue request and its tags
//   fu_result             per-unit results, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wb_ready              writeback consumer accepts this cycle
//   wb_valid/data/rob/dest/ctrl/fu         granted result (zero when idle)
//   fu_free               slot i can accept an issue this cycle
//   issue_err             registered pulse: last cycle's issue was dropped
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_ID_SIZE
`define ROB_ID_SIZE 6
`endif
`ifndef DEST_ADDR_SIZE
`define DEST_ADDR_SIZE 5
`endif

module exec_wb_arbiter
    import exec_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU        = 5,
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int ROB_SIZE      = `ROB_ID_SIZE,
    parameter int DEST_REG_SIZE = `DEST_ADDR_SIZE,
    parameter int CTRL_WIDTH    = 32,
    parameter int LAT_WIDTH     = LAT_WIDTH_DEFAULT,
    parameter int FU_IDX_W      = $clog2(NUM_FU)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [FU_IDX_W-1:0]          issue_fu,
    input  logic [LAT_WIDTH-1:0]         issue_latency,
    input  logic [ROB_SIZE-1:0]          issue_rob,
    input  logic [DEST_REG_SIZE-1:0]     issue_dest,
    input  logic [CTRL_WIDTH-1:0]        issue_ctrl,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    input  logic                         wb_ready,
    output logic                         wb_valid,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic [ROB_SIZE-1:0]          wb_rob,
    output logic [DEST_REG_SIZE-1:0]     wb_dest,
    output logic [CTRL_WIDTH-1:0]        wb_ctrl,
    output logic [FU_IDX_W-1:0]          wb_fu,
    output logic [NUM_FU-1:0]            fu_free,
    output logic                         issue_err
);

    slot_state_e              state_q [NUM_FU];
    slot_state_e              state_d [NUM_FU];
    logic [LAT_WIDTH-1:0]     cnt_q   [NUM_FU];
    logic [LAT_WIDTH-1:0]     cnt_d   [NUM_FU];
    logic [DATA_WIDTH-1:0]    data_q  [NUM_FU];
    logic [DATA_WIDTH-1:0]    data_d  [NUM_FU];
    logic [ROB_SIZE-1:0]      rob_q   [NUM_FU];
    logic [ROB_SIZE-1:0]      rob_d   [NUM_FU];
    logic [DEST_REG_SIZE-1:0] dest_q  [NUM_FU];
    logic [DEST_REG_SIZE-1:0] dest_d  [NUM_FU];
    logic [CTRL_WIDTH-1:0]    ctrl_q  [NUM_FU];
    logic [CTRL_WIDTH-1:0]    ctrl_d  [NUM_FU];

    logic [FU_IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                     lock_q, lock_d;
    logic [FU_IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic                     issue_err_q, issue_err_d;

    logic [NUM_FU-1:0]        done_vec;
    logic [NUM_FU-1:0]        arb_grant;
    logic [FU_IDX_W-1:0]      arb_idx;
    logic                     arb_valid;
    logic [FU_IDX_W-1:0]      sel_idx;
    logic [NUM_FU-1:0]        granted;
    logic [NUM_FU-1:0]        issue_hit;
    logic                     handshake;
    logic [LAT_WIDTH-1:0]     load_lat;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            done_vec[i] = (state_q[i] == SLOT_DONE);
        end
    end

    rr_arbiter #(
        .N     (NUM_FU),
        .IDX_W (FU_IDX_W)
    ) u_rr_arbiter (
        .req         (done_vec),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // A grant offered while the consumer stalls is pinned until it is taken,
    // so slots finishing later cannot steal the writeback port mid-stall.
    always_comb begin
        wb_valid  = arb_valid;
        sel_idx   = lock_q ? lock_idx_q : arb_idx;
        handshake = arb_valid && wb_ready;
        granted   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            granted[i] = arb_valid && (lock_q ? (lock_idx_q == FU_IDX_W'(i)) : arb_grant[i]);
        end
    end

    always_comb begin
        wb_data = '0;
        wb_rob  = '0;
        wb_dest = '0;
        wb_ctrl = '0;
        wb_fu   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (granted[i]) begin
                wb_data = data_q[i];
                wb_rob  = rob_q[i];
                wb_dest = dest_q[i];
                wb_ctrl = ctrl_q[i];
                wb_fu   = FU_IDX_W'(i);
            end
        end
    end

    // A DONE slot being drained this cycle is already free for a new issue.
    // Out-of-range issue_fu values match no slot and so fall through to error.
    always_comb begin
        fu_free   = '0;
        issue_hit = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_free[i]   = (state_q[i] == SLOT_IDLE) ||
                           ((state_q[i] == SLOT_DONE) && granted[i] && wb_ready);
            issue_hit[i] = issue_valid && (issue_fu == FU_IDX_W'(i)) && fu_free[i];
        end
        issue_err_d = issue_valid && !(|issue_hit);
        load_lat    = (issue_latency == '0) ? LAT_WIDTH'(1) : issue_latency;
    end

    // Slot lifecycle; an issue on the drain edge overrides the return to IDLE.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            data_d[i]  = data_q[i];
            rob_d[i]   = rob_q[i];
            dest_d[i]  = dest_q[i];
            ctrl_d[i]  = ctrl_q[i];
            case (state_q[i])
                SLOT_BUSY: begin
                    if (cnt_q[i] == LAT_WIDTH'(1)) begin
                        state_d[i] = SLOT_DONE;
                        cnt_d[i]   = '0;
                        data_d[i]  = fu_result[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        cnt_d[i] = cnt_q[i] - LAT_WIDTH'(1);
                    end
                end
                SLOT_DONE: begin
                    if (granted[i] && wb_ready) begin
                        state_d[i] = SLOT_IDLE;
                    end
                end
                SLOT_IDLE: begin
                    state_d[i] = SLOT_IDLE;
                end
                default: begin
                    state_d[i] = SLOT_IDLE;
                end
            endcase
            if (issue_hit[i]) begin
                state_d[i] = SLOT_BUSY;
                cnt_d[i]   = load_lat;
                rob_d[i]   = issue_rob;
                dest_d[i]  = issue_dest;
                ctrl_d[i]  = issue_ctrl;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = arb_valid && !wb_ready;
        lock_idx_d = sel_idx;
        if (handshake) begin
            rr_ptr_d = FU_IDX_W'(rr_next(int'(sel_idx), NUM_FU));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= SLOT_IDLE;
                cnt_q[i]   <= '0;
                data_q[i]  <= '0;
                rob_q[i]   <= '0;
                dest_q[i]  <= '0;
                ctrl_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            issue_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                data_q[i]  <= data_d[i];
                rob_q[i]   <= rob_d[i];
                dest_q[i]  <= dest_d[i];
                ctrl_q[i]  <= ctrl_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            issue_err_q <= issue_err_d;
        end
    end

    assign issue_err = issue_err_q;

endmodule

// File: tb/tb_exec_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exec_wb_arbiter
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level model that tracks each slot's due cycle and result.
// ---------------------------------------------------------------------------
module tb_exec_wb_arbiter;

    localparam int NFU = 5;
    localparam int DW  = 32;
    localparam int RW  = 6;
    localparam int DRW = 5;
    localparam int CW  = 32;
    localparam int LW  = 4;
    localparam int IW  = 3;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic [IW-1:0]     issue_fu;
    logic [LW-1:0]     issue_latency;
    logic [RW-1:0]     issue_rob;
    logic [DRW-1:0]    issue_dest;
    logic [CW-1:0]     issue_ctrl;
    logic [NFU*DW-1:0] fu_result;
    logic              wb_ready;
    logic              wb_valid;
    logic [DW-1:0]     wb_data;
    logic [RW-1:0]     wb_rob;
    logic [DRW-1:0]    wb_dest;
    logic [CW-1:0]     wb_ctrl;
    logic [IW-1:0]     wb_fu;
    logic [NFU-1:0]    fu_free;
    logic              issue_err;

    exec_wb_arbiter #(
        .NUM_FU        (NFU),
        .DATA_WIDTH    (DW),
        .ROB_SIZE      (RW),
        .DEST_REG_SIZE (DRW),
        .CTRL_WIDTH    (CW),
        .LAT_WIDTH     (LW),
        .FU_IDX_W      (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_fu      (issue_fu),
        .issue_latency (issue_latency),
        .issue_rob     (issue_rob),
        .issue_dest    (issue_dest),
        .issue_ctrl    (issue_ctrl),
        .fu_result     (fu_result),
        .wb_ready      (wb_ready),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rob        (wb_rob),
        .wb_dest       (wb_dest),
        .wb_ctrl       (wb_ctrl),
        .wb_fu         (wb_fu),
        .fu_free       (fu_free),
        .issue_err     (issue_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: per-slot status, absolute due cycle and captured result.
    int             m_st   [NFU];
    int             m_due  [NFU];
    logic [DW-1:0]  m_data [NFU];
    logic [RW-1:0]  m_rob  [NFU];
    logic [DRW-1:0] m_dest [NFU];
    logic [CW-1:0]  m_ctrl [NFU];
    int             m_ptr;
    bit             m_hold;
    int             m_hold_idx;
    bit             m_err;
    int             cyc;

    int checks;
    int errors;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NFU; i++) begin
            m_st[i]   = M_IDLE;
            m_due[i]  = 0;
            m_data[i] = '0;
            m_rob[i]  = '0;
            m_dest[i] = '0;
            m_ctrl[i] = '0;
        end
        m_ptr      = 0;
        m_hold     = 1'b0;
        m_hold_idx = 0;
        m_err      = 1'b0;
    endfunction

    // A stalled offer stays put; otherwise the first DONE slot from the pointer.
    function automatic void modelGrant(output int g, output bit v);
        g = 0;
        v = 1'b0;
        if (m_hold) begin
            g = m_hold_idx;
            v = 1'b1;
        end else begin
            for (int k = 0; k < NFU; k++) begin
                if (!v && m_st[(m_ptr + k) % NFU] == M_DONE) begin
                    g = (m_ptr + k) % NFU;
                    v = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [7:0] modelFree(input int g, input bit v);
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < NFU; i++) begin
            f[i] = (m_st[i] == M_IDLE) || (m_st[i] == M_DONE && v && g == i && wb_ready);
        end
        return f;
    endfunction

    task automatic checkModel();
        int g;
        bit v;
        logic [7:0] f;
        modelGrant(g, v);
        f = modelFree(g, v);
        checkOutput("wb_valid", 64'(wb_valid), 64'(v));
        checkOutput("wb_data", 64'(wb_data), v ? 64'(m_data[g]) : 64'd0);
        checkOutput("wb_rob", 64'(wb_rob), v ? 64'(m_rob[g]) : 64'd0);
        checkOutput("wb_dest", 64'(wb_dest), v ? 64'(m_dest[g]) : 64'd0);
        checkOutput("wb_ctrl", 64'(wb_ctrl), v ? 64'(m_ctrl[g]) : 64'd0);
        checkOutput("wb_fu", 64'(wb_fu), v ? 64'(g) : 64'd0);
        checkOutput("fu_free", 64'(fu_free), 64'(f[NFU-1:0]));
        checkOutput("issue_err", 64'(issue_err), 64'(m_err));
    endtask

    // Advance the model across the coming rising edge using the driven inputs.
    function automatic void modelStep();
        int g;
        bit v;
        bit hs;
        bit acc;
        int f;
        int e;
        int lat;
        logic [7:0] fr;
        modelGrant(g, v);
        fr  = modelFree(g, v);
        hs  = v && wb_ready;
        e   = cyc + 1;
        f   = int'(issue_fu);
        acc = issue_valid && (f < NFU) && fr[f];
        for (int i = 0; i < NFU; i++) begin
            if (m_st[i] == M_DONE && hs && g == i) begin
                m_st[i] = M_IDLE;
            end else if (m_st[i] == M_BUSY && m_due[i] == e) begin
                m_st[i]   = M_DONE;
                m_data[i] = fu_result[i*DW +: DW];
            end
        end
        if (acc) begin
            lat       = (int'(issue_latency) == 0) ? 1 : int'(issue_latency);
            m_st[f]   = M_BUSY;
            m_due[f]  = e + lat;
            m_rob[f]  = issue_rob;
            m_dest[f] = issue_dest;
            m_ctrl[f] = issue_ctrl;
        end
        m_hold     = v && !wb_ready;
        m_hold_idx = g;
        if (hs) m_ptr = (g + 1) % NFU;
        m_err = issue_valid && !acc;
        cyc   = e;
    endfunction

    task automatic applyStimulus(input bit v, input int fu, input int lat, input bit rdy);
        issue_valid   = v;
        issue_fu      = IW'(fu);
        issue_latency = LW'(lat);
        issue_rob     = RW'($urandom);
        issue_dest    = DRW'($urandom);
        issue_ctrl    = $urandom;
        wb_ready      = rdy;
    endtask

    task automatic randomResults();
        for (int i = 0; i < NFU; i++) fu_result[i*DW +: DW] = $urandom;
    endtask

    task automatic setResult(input int slot, input logic [DW-1:0] val);
        fu_result[slot*DW +: DW] = val;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic runCycle();
        #1;
        checkModel();
        modelStep();
        @(negedge clk);
    endtask

    task automatic resetDut();
        reset = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0);
        modelReset();
        @(negedge clk);
        #1;
        checkModel();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        fu_result = '0;
        resetDut();
        checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rst_fu_free", 64'(fu_free), 64'h1f);
        checkOutput("rst_issue_err", 64'(issue_err), 64'd0);

        // Slot 2, latency 3: result appears exactly three edges after issue.
        randomResults();
        setResult(2, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 2, 3, 1'b1);
        runCycle();
        applyStimulus(1'b0, 0, 0, 1'b1);
        runCycle();
        runCycle();
        checkOutput("lat3_not_early", 64'(wb_valid), 64'd0);
        runCycle();
        checkOutput("lat3_valid", 64'(wb_valid), 64'd1);
        checkOutput("lat3_data", 64'(wb_data), 64'hDEAD_BEEF);
        checkOutput("lat3_fu", 64'(wb_fu), 64'd2);
        runCycle();
        checkOutput("lat3_drained", 64'(wb_valid), 64'd0);

        // Slots 0,1,3 complete on the same edge; then pointer wrap from 4 to 0.
        resetDut();
        randomResults();
        applyStimulus(1'b1, 0, 3, 1'b1); runCycle();
        applyStimulus(1'b1, 1, 2, 1'b1); runCycle();
        applyStimulus(1'b1, 3, 1, 1'b1); runCycle();
        applyStimulus(1'b0, 0, 0, 1'b1); runCycle();
        checkOutput("rr_first", 64'(wb_fu), 64'd0);
        runCycle();
        checkOutput("rr_second", 64'(wb_fu), 64'd1);
        runCycle();
        checkOutput("rr_third", 64'(wb_fu), 64'd3);
        runCycle();
        checkOutput("rr_empty", 64'(wb_valid), 64'd0);
        applyStimulus(1'b1, 0, 2, 1'b0); runCycle();
        applyStimulus(1'b1, 4, 1, 1'b0); runCycle();
        applyStimulus(1'b0, 0, 0, 1'b0); runCycle();
        checkOutput("rr_ptr4", 64'(wb_fu), 64'd4);
        applyStimulus(1'b0, 0, 0, 1'b1); runCycle();
        checkOutput("rr_wrap", 64'(wb_fu), 64'd0);
        runCycle();

        // Stalled consumer: grant and data hold, re-issue to the held slot errors.
        resetDut();
        randomResults();
        setResult(1, 32'h1111_2222);
        applyStimulus(1'b1, 1, 1, 1'b0); runCycle();
        applyStimulus(1'b0, 0, 0, 1'b0); runCycle();
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_valid", 64'(wb_valid), 64'd1);
            checkOutput("stall_data", 64'(wb_data), 64'h1111_2222);
            checkOutput("stall_free1", 64'(fu_free[1]), 64'd0);
            randomResults();
            if (k == 2) applyStimulus(1'b1, 1, 2, 1'b0);
            else        applyStimulus(1'b0, 0, 0, 1'b0);
            runCycle();
            if (k == 2) checkOutput("stall_err", 64'(issue_err), 64'd1);
        end
        applyStimulus(1'b0, 0, 0, 1'b1); runCycle();
        checkOutput("stall_drain", 64'(wb_valid), 64'd0);

        // Drain and re-issue slot 0 on the same edge.
        resetDut();
        randomResults();
        setResult(0, 32'hAAAA_0001);
        applyStimulus(1'b1, 0, 1, 1'b0); runCycle();
        applyStimulus(1'b0, 0, 0, 1'b0); runCycle();
        applyStimulus(1'b1, 0, 1, 1'b1);
        setResult(0, 32'hBBBB_0002);
        #1;
        checkOutput("reiss_old", 64'(wb_data), 64'hAAAA_0001);
        checkOutput("reiss_free", 64'(fu_free[0]), 64'd1);
        runCycle();
        checkOutput("reiss_busy", 64'(wb_valid), 64'd0);
        applyStimulus(1'b0, 0, 0, 1'b0); runCycle();
        checkOutput("reiss_new", 64'(wb_data), 64'hBBBB_0002);

        // Latency 0 acts as 1; out-of-range slot index is rejected.
        resetDut();
        randomResults();
        setResult(3, 32'hC0FF_EE00);
        applyStimulus(1'b1, 3, 0, 1'b0); runCycle();
        checkOutput("lat0_busy", 64'(wb_valid), 64'd0);
        applyStimulus(1'b0, 0, 0, 1'b0); runCycle();
        checkOutput("lat0_done", 64'(wb_fu), 64'd3);
        checkOutput("lat0_data", 64'(wb_data), 64'hC0FF_EE00);
        applyStimulus(1'b1, 7, 2, 1'b0); runCycle();
        checkOutput("oob_err", 64'(issue_err), 64'd1);
        checkOutput("oob_free", 64'(fu_free), 64'h17);

        // Reset mid-flight discards three busy slots.
        resetDut();
        applyStimulus(1'b1, 0, 6, 1'b1); runCycle();
        applyStimulus(1'b1, 1, 6, 1'b1); runCycle();
        applyStimulus(1'b1, 2, 6, 1'b1); runCycle();
        resetDut();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1);
            runCycle();
            checkOutput("flush_valid", 64'(wb_valid), 64'd0);
            checkOutput("flush_free", 64'(fu_free), 64'h1f);
        end

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            randomResults();
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 7),
                          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4),
                          $urandom_range(0, 99) < 65);
            if ($urandom_range(0, 299) == 0) resetDut();
            else                             runCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_wb_arbiter.md
EXEC_WB_ARBITER -- requirements
Module: exec_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 5, number of functional-unit slots (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, result width.
REQ-003 SHALL have parameters ROB_SIZE = `ROB_ID_SIZE, DEST_REG_SIZE = `DEST_ADDR_SIZE, CTRL_WIDTH = 32, LAT_WIDTH = 4.
REQ-004 SHALL have parameter FU_IDX_W, default $clog2(NUM_FU), slot index width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 issue_valid  in  1  issue request this cycle.
REQ-008 issue_fu  in  FU_IDX_W  target slot.
REQ-009 issue_latency  in  LAT_WIDTH  cycles until result is valid.
REQ-010 issue_rob / issue_dest / issue_ctrl  in  ROB_SIZE / DEST_REG_SIZE / CTRL_WIDTH  tag fields.
REQ-011 fu_result  in  NUM_FU*DATA_WIDTH  per-unit datapath results, slot i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 wb_ready  in  1  writeback consumer accepts.
REQ-013 wb_valid / wb_data / wb_rob / wb_dest / wb_ctrl / wb_fu  out  1 / DATA_WIDTH / ROB_SIZE / DEST_REG_SIZE / CTRL_WIDTH / FU_IDX_W  granted result.
REQ-014 fu_free  out  NUM_FU  slot i can accept an issue this cycle.
REQ-015 issue_err  out  1  registered pulse: issue to non-free slot or out-of-range index was dropped.

Function
REQ-016 Each slot SHALL be in one of IDLE, BUSY, DONE.
REQ-017 IDLE + accepted issue SHALL load counter = max(issue_latency,1), capture tags, go BUSY.
REQ-018 BUSY SHALL decrement counter each cycle; on the edge where counter==1 it SHALL capture fu_result[i] into the slot hold register and go DONE (result visible exactly L cycles after the issue edge).
REQ-019 DONE SHALL hold data and tags until granted with wb_valid && wb_ready, then go IDLE, or BUSY if re-issued on the same edge.
REQ-020 fu_free[i] SHALL be 1 in IDLE, and in DONE when slot i is granted and wb_ready=1 this cycle; 0 otherwise (combinational).
REQ-021 Issue SHALL be accepted only when issue_valid && issue_fu<NUM_FU && fu_free[issue_fu]; otherwise issue_err SHALL pulse one cycle later and no state SHALL change.
REQ-022 Arbitration SHALL be round-robin over DONE slots starting at rr_ptr; wb_valid SHALL be 1 iff any slot is DONE; wb_* SHALL reflect the granted slot combinationally.
REQ-023 wb_data/wb_rob/wb_dest/wb_ctrl/wb_fu SHALL be zero when wb_valid=0.
REQ-024 On handshake rr_ptr SHALL become (granted+1) mod NUM_FU, wrapping at NUM_FU-1 -> 0; without handshake rr_ptr SHALL hold.
REQ-025 With wb_ready=0 the grant SHALL stay stable (no re-arbitration while wb_valid held).
REQ-026 Slots SHALL complete independently; multiple slots reaching DONE on the same edge SHALL all be held, none lost.

Reset
REQ-027 While reset=0: all slots IDLE, counters 0, rr_ptr 0, issue_err 0, hold registers 0; hence wb_valid=0, wb_* 0, fu_free all 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight and DONE results with no writeback.

Structure
REQ-029 Slot state encoding and LAT_WIDTH default SHALL live in the shared globals package/header.
REQ-030 Round-robin selection SHALL be one sub-module rr_arbiter (request vector, pointer -> one-hot grant + index).

Verification
REQ-031 Issue slot 2, latency 3, fu_result[2]=0xDEAD_BEEF, wb_ready=1 -> wb_valid high exactly 3 cycles after issue edge, wb_data=0xDEADBEEF, wb_fu=2.
REQ-032 Slots 0,1,3 DONE together, wb_ready=1, rr_ptr=0 -> grants 0,1,3 on consecutive cycles; rr_ptr ends 4.
REQ-033 Slot 1 DONE, wb_ready=0 for 5 cycles -> wb_valid/wb_data stable, fu_free[1]=0; issue to slot 1 -> issue_err pulses next cycle.
REQ-034 Slot 0 DONE, granted with wb_ready=1 while issue_fu=0 latency 1 same cycle -> old result written back, new result DONE next edge.
REQ-035 Issue latency 0 -> behaves as latency 1; issue_fu=7 with NUM_FU=5 -> issue_err, no state change.
REQ-036 Three slots BUSY, reset pulsed low -> wb_valid never asserts for them, fu_free=all ones.
